mips_multicycle_control: RTL and testbench

Multi-cycle control unit for the coursework MIPS CPU. It holds the instruction register and sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory bus that uses a `waitrequest` handshake. It drives registered-state control strobes to the datapath (PC, register file, ALU, memory interface) for the supported instruction subset. It replaces the purely combinational decoder with a stall-aware FSM, parametrised ALU-op width, and halt/fault detection.

---
 rtl/mips_multicycle_control.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: owns the IR and sequences FETCH/DECODE/EXEC/MEM/WB over a waitrequest bus.
// Optional bus-stall watchdog enabled by defining MIPS_CTRL_TIMEOUT_EN (adds parameter TIMEOUT_CYCLES).
module mips_multicycle_control #(
  parameter int unsigned ALU_OP_WIDTH = 4
`ifdef MIPS_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    waitrequest,
  input  logic [31:0]             readdata,
  input  logic                    alu_zero,
  input  logic                    pc_is_zero,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    iord,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    reg_write,
  output logic [1:0]              pc_src,
  output logic [1:0]              alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic [31:0]             instr,
  output logic                    active,
  output logic                    fault,
  output logic [2:0]              state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;
  localparam logic [2:0] FAULT  = 3'd6;

  localparam logic [2:0] K_ILL = 3'd0;
  localparam logic [2:0] K_ALU = 3'd1;
  localparam logic [2:0] K_LW  = 3'd2;
  localparam logic [2:0] K_SW  = 3'd3;
  localparam logic [2:0] K_BEQ = 3'd4;
  localparam logic [2:0] K_BNE = 3'd5;
  localparam logic [2:0] K_J   = 3'd6;
  localparam logic [2:0] K_JR  = 3'd7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI  = ALU_OP_WIDTH'(6);

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_SEXT = 2'd1;
  localparam logic [1:0] SRC_B_ZEXT = 2'd2;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  logic [2:0]              state_q, state_d;
  logic [31:0]             instr_q, instr_d;
  logic [5:0]              opcode;
  logic [5:0]              funct;
  logic [2:0]              kind_c;
  logic [ALU_OP_WIDTH-1:0] dec_alu_op_c;
  logic [1:0]              dec_src_b_c;
  logic                    dec_reg_dst_c;
  logic                    timeout_c;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];
  assign instr  = instr_q;
  assign state  = state_q;

  // Instruction class and ALU controls; unknown encodings fall through as K_ILL.
  always_comb begin : decode
    kind_c        = K_ILL;
    dec_alu_op_c  = ALU_ADD;
    dec_src_b_c   = SRC_B_RT;
    dec_reg_dst_c = 1'b0;
    case (opcode)
      6'h00: begin
        kind_c        = K_ALU;
        dec_reg_dst_c = 1'b1;
        case (funct)
          6'h21: dec_alu_op_c = ALU_ADD;
          6'h23: dec_alu_op_c = ALU_SUB;
          6'h24: dec_alu_op_c = ALU_AND;
          6'h25: dec_alu_op_c = ALU_OR;
          6'h26: dec_alu_op_c = ALU_XOR;
          6'h2B: dec_alu_op_c = ALU_SLTU;
          6'h08: begin
            kind_c        = K_JR;
            dec_reg_dst_c = 1'b0;
          end
          default: begin
            kind_c        = K_ILL;
            dec_reg_dst_c = 1'b0;
          end
        endcase
      end
      6'h02: kind_c = K_J;
      6'h04: begin
        kind_c       = K_BEQ;
        dec_alu_op_c = ALU_SUB;
      end
      6'h05: begin
        kind_c       = K_BNE;
        dec_alu_op_c = ALU_SUB;
      end
      6'h09: begin
        kind_c      = K_ALU;
        dec_src_b_c = SRC_B_SEXT;
      end
      6'h0C: begin
        kind_c       = K_ALU;
        dec_alu_op_c = ALU_AND;
        dec_src_b_c  = SRC_B_ZEXT;
      end
      6'h0D: begin
        kind_c       = K_ALU;
        dec_alu_op_c = ALU_OR;
        dec_src_b_c  = SRC_B_ZEXT;
      end
      6'h0E: begin
        kind_c       = K_ALU;
        dec_alu_op_c = ALU_XOR;
        dec_src_b_c  = SRC_B_ZEXT;
      end
      6'h0F: begin
        kind_c       = K_ALU;
        dec_alu_op_c = ALU_LUI;
        dec_src_b_c  = SRC_B_ZEXT;
      end
      6'h23: begin
        kind_c      = K_LW;
        dec_src_b_c = SRC_B_SEXT;
      end
      6'h2B: begin
        kind_c      = K_SW;
        dec_src_b_c = SRC_B_SEXT;
      end
      default: kind_c = K_ILL;
    endcase
  end

`ifdef MIPS_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic            bus_stall_c;

  // Consecutive stalled bus cycles; the TIMEOUT_CYCLES-th one forces FAULT at its closing edge.
  assign bus_stall_c = waitrequest &&
                       (((state_q == FETCH) && !pc_is_zero) || (state_q == MEM));
  assign timeout_c   = bus_stall_c && (stall_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign stall_cnt_d = bus_stall_c ? stall_cnt_q + CntW'(1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next state and control strobes; all strobes are forced low while reset_n is asserted.
  always_comb begin : fsm_comb
    state_d    = state_q;
    instr_d    = instr_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = PC_SRC_INC;
    alu_src_b  = SRC_B_RT;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    active     = (state_q != HALT) && (state_q != FAULT);
    fault      = (state_q == FAULT);
    case (state_q)
      FETCH: begin
        if (pc_is_zero) begin
          state_d = HALT;
        end else begin
          mem_read = 1'b1;
          ir_write = !waitrequest;
          pc_write = !waitrequest;
          if (!waitrequest) begin
            instr_d = readdata;
            state_d = DECODE;
          end else if (timeout_c) begin
            state_d = FAULT;
          end
        end
      end
      DECODE: state_d = (kind_c == K_ILL) ? FAULT : EXEC;
      EXEC: begin
        alu_op    = dec_alu_op_c;
        alu_src_b = dec_src_b_c;
        reg_dst   = dec_reg_dst_c;
        case (kind_c)
          K_ALU:      state_d = WB;
          K_LW, K_SW: state_d = MEM;
          K_BEQ: begin
            pc_write = alu_zero;
            pc_src   = PC_SRC_BRANCH;
            state_d  = FETCH;
          end
          K_BNE: begin
            pc_write = !alu_zero;
            pc_src   = PC_SRC_BRANCH;
            state_d  = FETCH;
          end
          K_J: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            state_d  = FETCH;
          end
          K_JR: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_RS;
            state_d  = FETCH;
          end
          default: state_d = FAULT;
        endcase
      end
      MEM: begin
        iord      = 1'b1;
        mem_read  = (kind_c == K_LW);
        mem_write = (kind_c == K_SW);
        if (!waitrequest)   state_d = (kind_c == K_LW) ? WB : FETCH;
        else if (timeout_c) state_d = FAULT;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = dec_reg_dst_c;
        mem_to_reg = (kind_c == K_LW);
        state_d    = FETCH;
      end
      default: state_d = state_q;
    endcase
    if (!reset_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-cycle expected control words queued and checked.
module tb_mips_multicycle_control;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_OR = 4'd3, A_SLTU = 4'd5, A_LUI = 4'd6;

  typedef struct packed {
    logic [2:0] st;
    logic       mr, mw, iord, irw, pcw, rw;
    logic [1:0] pcsrc, srcb;
    logic [3:0] aluop;
    logic       rdst, m2r, active, fault;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        reset_n, waitrequest, alu_zero, pc_is_zero;
  logic [31:0] readdata;
  logic        mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_dst, mem_to_reg, active, fault;
  logic [31:0] instr;
  logic [2:0]  state;
  ctrl_t       obs;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  ctrl_t       sb_q[$];

  always #5 clk = ~clk;

  mips_multicycle_control #(
    .ALU_OP_WIDTH(4)
`ifdef MIPS_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .readdata(readdata),
    .alu_zero(alu_zero), .pc_is_zero(pc_is_zero),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr(instr),
    .active(active), .fault(fault), .state(state)
  );

  assign obs = {state, mem_read, mem_write, iord, ir_write, pc_write, reg_write,
                pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg, active, fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t e_idle(input logic [2:0] st);
    ctrl_t e = '0;
    e.st     = st;
    e.active = (st != S_HALT) && (st != S_FAULT);
    e.fault  = (st == S_FAULT);
    return e;
  endfunction

  function automatic ctrl_t e_fetch(input logic stall);
    ctrl_t e = e_idle(S_FETCH);
    e.mr  = 1'b1;
    e.irw = !stall;
    e.pcw = !stall;
    return e;
  endfunction

  function automatic ctrl_t e_exec(input logic [3:0] op, input logic [1:0] srcb, input logic rdst,
                                   input logic pcw, input logic [1:0] pcsrc);
    ctrl_t e = e_idle(S_EXEC);
    e.aluop = op;
    e.srcb  = srcb;
    e.rdst  = rdst;
    e.pcw   = pcw;
    e.pcsrc = pcsrc;
    return e;
  endfunction

  function automatic ctrl_t e_mem(input logic lw);
    ctrl_t e = e_idle(S_MEM);
    e.iord = 1'b1;
    e.mr   = lw;
    e.mw   = !lw;
    return e;
  endfunction

  function automatic ctrl_t e_wb(input logic rdst, input logic m2r);
    ctrl_t e = e_idle(S_WB);
    e.rw   = 1'b1;
    e.rdst = rdst;
    e.m2r  = m2r;
    return e;
  endfunction

  // One clock: called at a negedge, drives inputs, checks outputs 1ns later, returns at the next negedge.
  task automatic step(input string tag, input logic wr, input logic az, input logic pcz,
                      input logic [31:0] rd, input ctrl_t exp);
    ctrl_t e;
    waitrequest = wr;
    alu_zero    = az;
    pc_is_zero  = pcz;
    readdata    = rd;
    sb_q.push_back(exp);
    #1;
    e = sb_q.pop_front();
    check(tag, 32'(obs), 32'(e));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    ctrl_t e;
    reset_n     = 1'b0;
    waitrequest = 1'b0;
    pc_is_zero  = 1'b0;
    readdata    = $urandom();
    sb_q.push_back(e_idle(S_FETCH));
    #1;
    e = sb_q.pop_front();
    check({tag, ".ctrl"}, 32'(obs), 32'(e));
    check({tag, ".ir"}, instr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic fetch(input string t, input logic [31:0] ins, input int nwait);
    for (int i = 0; i < nwait; i++) step({t, ".fstall"}, 1'b1, 1'b0, 1'b0, $urandom(), e_fetch(1'b1));
    step({t, ".fetch"}, 1'b0, 1'b0, 1'b0, ins, e_fetch(1'b0));
    step({t, ".dec"}, 1'b0, 1'b0, 1'b0, $urandom(), e_idle(S_DEC));
    check({t, ".ir"}, instr, ins);
  endtask

  task automatic exec(input string t, input logic az, input ctrl_t exp);
    step({t, ".exec"}, 1'b0, az, 1'b0, $urandom(), exp);
  endtask

  initial begin
    ctrl_t e;
    reset_n     = 1'b0;
    waitrequest = 1'b0;
    alu_zero    = 1'b0;
    pc_is_zero  = 1'b0;
    readdata    = '0;
    @(negedge clk);
    do_reset("rst0");

    fetch("addu", 32'h00851021, 0);
    exec("addu", 1'b0, e_exec(A_ADD, 2'd0, 1'b1, 1'b0, 2'd0));
    step("addu.wb", 1'b0, 1'b0, 1'b0, $urandom(), e_wb(1'b1, 1'b0));

    fetch("lw", 32'h8C820004, 0);
    exec("lw", 1'b0, e_exec(A_ADD, 2'd1, 1'b0, 1'b0, 2'd0));
    step("lw.mstall0", 1'b1, 1'b0, 1'b0, $urandom(), e_mem(1'b1));
    step("lw.mstall1", 1'b1, 1'b0, 1'b0, $urandom(), e_mem(1'b1));
    step("lw.mem", 1'b0, 1'b0, 1'b0, $urandom(), e_mem(1'b1));
    step("lw.wb", 1'b0, 1'b0, 1'b0, $urandom(), e_wb(1'b0, 1'b1));

    fetch("beq_t", 32'h10850003, 2);
    exec("beq_t", 1'b1, e_exec(A_SUB, 2'd0, 1'b0, 1'b1, 2'd1));
    fetch("beq_n", 32'h10850003, 0);
    exec("beq_n", 1'b0, e_exec(A_SUB, 2'd0, 1'b0, 1'b0, 2'd1));
    fetch("bne_z", 32'h14850003, 0);
    exec("bne_z", 1'b1, e_exec(A_SUB, 2'd0, 1'b0, 1'b0, 2'd1));
    fetch("bne_nz", 32'h14850003, 0);
    exec("bne_nz", 1'b0, e_exec(A_SUB, 2'd0, 1'b0, 1'b1, 2'd1));

    fetch("ori", 32'h34A5FFFF, 0);
    exec("ori", 1'b0, e_exec(A_OR, 2'd2, 1'b0, 1'b0, 2'd0));
    step("ori.wb", 1'b0, 1'b0, 1'b0, $urandom(), e_wb(1'b0, 1'b0));
    fetch("sltu", 32'h0085102B, 0);
    exec("sltu", 1'b0, e_exec(A_SLTU, 2'd0, 1'b1, 1'b0, 2'd0));
    step("sltu.wb", 1'b0, 1'b0, 1'b0, $urandom(), e_wb(1'b1, 1'b0));
    fetch("lui", 32'h3C011234, 0);
    exec("lui", 1'b0, e_exec(A_LUI, 2'd2, 1'b0, 1'b0, 2'd0));
    step("lui.wb", 1'b0, 1'b0, 1'b0, $urandom(), e_wb(1'b0, 1'b0));

    fetch("sw", 32'hAC820008, 0);
    exec("sw", 1'b0, e_exec(A_ADD, 2'd1, 1'b0, 1'b0, 2'd0));
    step("sw.mem", 1'b0, 1'b0, 1'b0, $urandom(), e_mem(1'b0));

    fetch("j", 32'h08000010, 0);
    exec("j", 1'b0, e_exec(A_ADD, 2'd0, 1'b0, 1'b1, 2'd2));
    fetch("jr", 32'h03E00008, 0);
    exec("jr", 1'b0, e_exec(A_ADD, 2'd0, 1'b0, 1'b1, 2'd3));

    // PC wrapped to zero: no fetch strobe, then absorbing HALT
    step("halt.entry", 1'b0, 1'b0, 1'b1, $urandom(), e_idle(S_FETCH));
    step("halt.0", 1'b0, 1'b0, 1'b0, $urandom(), e_idle(S_HALT));
    step("halt.1", 1'b1, 1'b1, 1'b1, $urandom(), e_idle(S_HALT));
    step("halt.2", 1'b0, 1'b0, 1'b0, $urandom(), e_idle(S_HALT));

    do_reset("rst1");
    fetch("ill_op", 32'hFC000000, 0);
    step("ill_op.f0", 1'b0, 1'b0, 1'b0, $urandom(), e_idle(S_FAULT));
    step("ill_op.f1", 1'b1, 1'b1, 1'b0, $urandom(), e_idle(S_FAULT));
    step("ill_op.f2", 1'b0, 1'b0, 1'b1, $urandom(), e_idle(S_FAULT));

    do_reset("rst2");
    fetch("ill_fn", 32'h00000000, 0);
    step("ill_fn.f0", 1'b0, 1'b0, 1'b0, $urandom(), e_idle(S_FAULT));

    do_reset("rst3");
    fetch("sw_rst", 32'hAC820008, 0);
    exec("sw_rst", 1'b0, e_exec(A_ADD, 2'd1, 1'b0, 1'b0, 2'd0));
    step("sw_rst.mstall", 1'b1, 1'b0, 1'b0, $urandom(), e_mem(1'b0));
    // Reset pulled low mid-phase while SW is still stalled in MEM
    waitrequest = 1'b1;
    #3;
    reset_n = 1'b0;
    sb_q.push_back(e_idle(S_FETCH));
    #1;
    e = sb_q.pop_front();
    check("sw_rst.async", 32'(obs), 32'(e));
    check("sw_rst.async_ir", instr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    fetch("addiu", 32'h24420001, 0);
    exec("addiu", 1'b0, e_exec(A_ADD, 2'd1, 1'b0, 1'b0, 2'd0));
    step("addiu.wb", 1'b0, 1'b0, 1'b0, $urandom(), e_wb(1'b0, 1'b0));

`ifdef MIPS_CTRL_TIMEOUT_EN
    do_reset("rst4");
    fetch("to7", 32'h00851021, 7);
    do_reset("rst5");
    for (int i = 0; i < 8; i++) step("to8.fstall", 1'b1, 1'b0, 1'b0, $urandom(), e_fetch(1'b1));
    step("to8.fault", 1'b1, 1'b0, 1'b0, $urandom(), e_idle(S_FAULT));
    step("to8.hold", 1'b0, 1'b0, 1'b0, $urandom(), e_idle(S_FAULT));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
